// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN datapath constants and state encoding
package cnn_pkg;

  localparam int CLASS_W     = 4;
  localparam int SCORE_W     = 16;
  localparam int NUM_CLASSES = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fc_argmax.sv
// rtl/fc_argmax.sv - running-maximum argmax over streamed signed class scores
import cnn_pkg::*;

module fc_argmax #(
  parameter int NUM_CLASSES = cnn_pkg::NUM_CLASSES,
  parameter int DATA_W      = cnn_pkg::SCORE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_flag,
  input  logic                score_valid,
  input  logic [DATA_W-1:0]   score_data,
  output logic                score_ready,
  output logic [CLASS_W-1:0]  out,
  output logic [DATA_W-1:0]   max_score,
  output logic                over_flag,
  output logic                done_pulse
);

  localparam int CNT_W = $clog2(NUM_CLASSES);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_CLASSES - 1);

  state_t                   state_q;
  state_t                   state_d;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         best_idx;
  logic signed [DATA_W-1:0] best_val;
  logic                     xfer;
  logic                     take_new;
  logic                     last_xfer;
  logic                     start_ok;
  logic [CNT_W-1:0]         win_idx;
  logic [DATA_W-1:0]        win_val;

  // Ready decodes the state register only, so there is no input-to-output path.
  assign score_ready = (state_q == ACCUM);
  assign xfer        = score_valid && score_ready;
  assign start_ok    = start_flag && ((state_q == IDLE) || (state_q == DONE));
  // The first score always loads; afterwards only a strictly greater one replaces,
  // which makes the lowest index win on ties.
  assign take_new    = (cnt == '0) || ($signed(score_data) > best_val);
  assign last_xfer   = xfer && (cnt == LAST_IDX);
  // Winner including the score arriving this cycle, used when the last one lands.
  assign win_idx     = take_new ? cnt : best_idx;
  assign win_val     = take_new ? score_data : best_val;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode; start is ignored while accumulating.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_flag) state_d = ACCUM;
      ACCUM:   if (last_xfer)  state_d = DONE;
      DONE:    if (start_flag) state_d = ACCUM;
      default: state_d = IDLE;
    endcase
  end

  // Compare-and-update of the running maximum plus registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      best_idx   <= '0;
      best_val   <= MOST_NEG;
      out        <= '0;
      max_score  <= '0;
      over_flag  <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (start_ok) begin
        cnt       <= '0;
        best_idx  <= '0;
        best_val  <= MOST_NEG;
        out       <= '0;
        max_score <= '0;
        over_flag <= 1'b0;
      end else if (xfer) begin
        if (take_new) begin
          best_val <= $signed(score_data);
          best_idx <= cnt;
        end
        cnt <= cnt + 1'b1;
        if (last_xfer) begin
          out        <= CLASS_W'(win_idx);
          max_score  <= win_val;
          over_flag  <= 1'b1;
          done_pulse <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fc_argmax.sv
// tb/tb_fc_argmax.sv - directed self-checking bench for fc_argmax
module tb_fc_argmax;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_flag;
  logic        score_valid;
  logic [15:0] score_data;
  logic        score_ready;
  logic [3:0]  out;
  logic [15:0] max_score;
  logic        over_flag;
  logic        done_pulse;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  logic [15:0] sc [10];

  fc_argmax dut (
    .clk         (clk),
    .rst         (rst),
    .start_flag  (start_flag),
    .score_valid (score_valid),
    .score_data  (score_data),
    .score_ready (score_ready),
    .out         (out),
    .max_score   (max_score),
    .over_flag   (over_flag),
    .done_pulse  (done_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge.
  task automatic do_start();
    start_flag = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start_flag = 1'b0;
    chk("ready_after_start", {31'b0, score_ready}, 32'd1);
    chk("over_clear_after_start", {31'b0, over_flag}, 32'd0);
  endtask

  // Feeds sc[0..n-1]; optional 3-cycle stall before item stall_at, start pulse
  // alongside item mid_at, and start held from the last item into DONE.
  task automatic feed(input int n, input int stall_at, input int mid_at, input bit hold_end);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        score_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("ready_in_stall", {31'b0, score_ready}, 32'd1);
      end
      score_valid = 1'b1;
      score_data  = sc[i];
      start_flag  = (i == mid_at) || (hold_end && i == n - 1);
      @(negedge clk);
      if (i < 9) chk("no_over_early", {31'b0, over_flag}, 32'd0);
    end
    score_valid = 1'b0;
    score_data  = 16'h0;
    if (!hold_end) start_flag = 1'b0;
  endtask

  task automatic chk_done(input string tag, input logic [3:0] eo, input logic [15:0] em);
    chk({tag, "_out"}, {28'b0, out}, {28'b0, eo});
    chk({tag, "_max"}, {16'b0, max_score}, {16'b0, em});
    chk({tag, "_over"}, {31'b0, over_flag}, 32'd1);
    chk({tag, "_pulse"}, {31'b0, done_pulse}, 32'd1);
    chk({tag, "_ready"}, {31'b0, score_ready}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start_flag = 1'b0; score_valid = 1'b0; score_data = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, score_ready}, 32'd0);
    chk("rst_out", {28'b0, out}, 32'd0);
    chk("rst_max", {16'b0, max_score}, 32'd0);
    chk("rst_over", {31'b0, over_flag}, 32'd0);
    chk("rst_pulse", {31'b0, done_pulse}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Ascending 0..9: last score wins, 11-cycle completion.
    sc = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    do_start();
    feed(10, -1, -1, 1'b0);
    chk_done("asc", 4'd9, 16'd9);
    chk("asc_latency", cyc - t0, 32'd11);
    @(negedge clk);
    chk("asc_pulse_once", {31'b0, done_pulse}, 32'd0);
    chk("asc_over_level", {31'b0, over_flag}, 32'd1);

    // All negative: signed compare and most-negative init.
    sc = '{-16'sd100, -16'sd5, -16'sd7, -16'sd300, -16'sd20,
           -16'sd40, -16'sd60, -16'sd80, -16'sd99, -16'sd50};
    do_start();
    feed(10, -1, -1, 1'b0);
    chk_done("neg", 4'd1, 16'hFFFB);

    // Ties: lowest index wins.
    sc = '{16'd3, 16'd8, 16'd8, 16'd2, 16'd8, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    do_start();
    feed(10, -1, -1, 1'b0);
    chk_done("tie", 4'd1, 16'd8);

    // 3-cycle stall after class 4, positive-max winner at class 7.
    sc = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'h7FFF, 16'd100, 16'd200};
    do_start();
    feed(10, 5, -1, 1'b0);
    chk_done("stall", 4'd7, 16'h7FFF);
    chk("stall_latency", cyc - t0, 32'd14);

    // Reset mid-inference, then a fresh run with the max at class 0.
    sc = '{16'd900, 16'd901, 16'd902, 16'd903, 16'd904, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    do_start();
    feed(5, -1, -1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", {31'b0, score_ready}, 32'd0);
    chk("midrst_over", {31'b0, over_flag}, 32'd0);
    chk("midrst_out", {28'b0, out}, 32'd0);
    sc = '{16'd500, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    do_start();
    feed(10, -1, -1, 1'b0);
    chk_done("fresh", 4'd0, 16'd500);

    // Back-to-back inferences with start held into DONE, mid-ACCUM start ignored.
    sc = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80, 16'd90, 16'd100};
    do_start();
    feed(10, -1, -1, 1'b1);
    chk_done("runa", 4'd9, 16'd100);
    @(negedge clk);
    start_flag = 1'b0;
    chk("runb_over_drop", {31'b0, over_flag}, 32'd0);
    chk("runb_pulse_once", {31'b0, done_pulse}, 32'd0);
    chk("runb_out_clr", {28'b0, out}, 32'd0);
    chk("runb_max_clr", {16'b0, max_score}, 32'd0);
    chk("runb_ready", {31'b0, score_ready}, 32'd1);
    sc = '{16'd5, 16'd6, 16'd900, 16'd7, 16'd8, 16'd1, 16'd2, 16'd3, 16'd4, 16'd899};
    feed(10, -1, 4, 1'b0);
    chk_done("runb", 4'd2, 16'd900);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fc_argmax.md
# fc_argmax

Final classification stage of the CNN datapath. It consumes the signed class scores streamed out of the fully-connected layer, one per cycle under a valid/ready handshake, and tracks the running maximum. When the last score arrives it presents the winning class index as the 4-bit digit result and raises the completion flag. The top level reads these as `out` and `over_flag`.

## Interface
- `NUM_CLASSES`, default 10: number of scores per inference (2..16).
- `DATA_W`, default 16: width of each signed two's-complement score.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start_flag`  in  1: begin a new inference; sampled only in IDLE or DONE.
- `score_valid`  in  1: `score_data` is valid this cycle.
- `score_data`  in  DATA_W: signed class score, class order 0..NUM_CLASSES-1.
- `score_ready`  out  1: high only in ACCUM; a transfer occurs when valid and ready are both high.
- `out`  out  4: index of the winning class.
- `max_score`  out  DATA_W: score of the winning class.
- `over_flag`  out  1: level; high in DONE until the next accepted start or reset.
- `done_pulse`  out  1: one-cycle strobe on entry to DONE.

## Operation
- FSM states:
  - IDLE: reset state.
  - ACCUM: collecting scores.
  - DONE: result held.
- IDLE/DONE --start_flag--> ACCUM.
  - On this transition: `cnt`=0, `best_idx`=0, `best_val`=most-negative value.
  - Also clear `over_flag`, `out` and `max_score`.
- ACCUM, per accepted transfer:
  - If `cnt`==0 or `score_data` > `best_val` (signed, strictly greater), load `best_val`←`score_data` and `best_idx`←`cnt`.
  - `cnt`←`cnt`+1.
- ACCUM --transfer with `cnt`==NUM_CLASSES-1--> DONE.
  - `out`/`max_score` take the final winner, including the last score if it is the winner.
  - `over_flag`←1 and `done_pulse`←1.
- Ties: the lowest index wins, because replacement requires strictly greater.
- `score_valid` low in ACCUM: stall. No state change, no timeout.
- `score_valid` outside ACCUM: ignored, since ready is low.
- `start_flag` in ACCUM: ignored. The inference continues.
- Comparison uses `$signed` at full DATA_W. There is no arithmetic, so there is no overflow.

## Timing
- Reset values: `score_ready`=0, `out`=0, `max_score`=0, `over_flag`=0, `done_pulse`=0, FSM=IDLE, `cnt`=0.
- `rst` asserted mid-ACCUM returns the block to IDLE on the next edge and discards the partial result.
- `rst` has priority over `start_flag`.
- `score_ready` rises the cycle after `start_flag` is sampled.
- With back-to-back valid, the last score is accepted at cycle N.
  - Cycle N+1: `over_flag`=1 and `done_pulse`=1; `out` and `max_score` are valid and registered.
  - `score_ready`=0 from cycle N+1.
- Minimum inference: 1 start cycle, NUM_CLASSES transfer cycles, then DONE on the next edge.
- `start_flag` held high through DONE starts a new inference on the first DONE cycle.
  - This clears `over_flag` after one cycle.
  - `done_pulse` still fires once.
- All outputs are registered. There are no combinational paths from inputs to outputs except `score_ready`, which decodes the state register only.

## Structure
- Shared `cnn_pkg` holds:
  - `CLASS_W`=4 and `SCORE_W`=16;
  - `NUM_CLASSES`=10;
  - the state typedef (IDLE, ACCUM, DONE).
- `cnt` width is `$clog2(NUM_CLASSES)` and `out` is zero-extended to 4 bits.
- Single flat module. The compare-and-update is one always block, so no sub-module is warranted.

## Test plan
- Ascending scores 0..9, back-to-back, start at cycle 1 → `out`=9, `max_score`=9, `over_flag`=1 and `done_pulse`=1 exactly 11 cycles after start.
- All negative: -100,-5,-7,-300,…,-50 → `out`=1, `max_score`=-5. This checks signed compare and the most-negative init.
- Ties: scores 3,8,8,2,8,0,0,0,0,0 → `out`=1 (lowest index).
- Valid deasserted for 3 cycles after class 4; winner is class 7 with score 0x7FFF → `out`=7, `max_score`=0x7FFF, and completion is delayed by exactly 3 cycles.
- `rst` pulsed after 5 scores, then a fresh inference with max at class 0 → `out`=0, and no `over_flag` before the fresh run ends.
- Two consecutive inferences with `start_flag` asserted in DONE:
  - `over_flag` drops for the second run.
  - The second result is independent of the first: winners 9 then 2.
  - `start_flag` pulsed mid-ACCUM has no effect.
